// File: rtl/pmem_line_responder_pkg.sv
// Shared types for the pmem line responder.
// Line/word typedefs, beat index and FSM states.
package pmem_line_responder_pkg;

  localparam int WORD_W_P       = 16;
  localparam int LINE_W_P       = 128;
  localparam int BEATS_PER_LINE = 8;

  typedef logic [WORD_W_P-1:0] lc3b_word;
  typedef logic [LINE_W_P-1:0] lc3b_cache_line;
  typedef logic [2:0]          lc3b_beat_idx;
  typedef logic [11:0]         lc3b_line_addr;

  typedef enum logic [1:0] {
    IDLE,
    RD_BEAT,
    WR_BEAT,
    RESP
  } lc3b_pmem_state;

  function automatic lc3b_word beat_addr(
    input lc3b_line_addr line,
    input lc3b_beat_idx  beat
  );
    return {line, beat, 1'b0};
  endfunction

endpackage

// File: rtl/pmem_line_responder_if.sv
// Cache pmem line port plus word-wide backing port.
// slave = responder side, master = cache/memory side.
interface pmem_line_responder_if;
  import pmem_line_responder_pkg::*;

  logic           pmem_read;
  logic           pmem_write;
  lc3b_word       pmem_address;
  lc3b_cache_line pmem_wdata;
  lc3b_cache_line pmem_rdata;
  logic           pmem_resp;

  logic           bk_req;
  logic           bk_we;
  lc3b_word       bk_addr;
  lc3b_word       bk_wdata;
  lc3b_word       bk_rdata;
  logic           bk_ack;

  modport slave (
    input  pmem_read, pmem_write,
    input  pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp,
    output bk_req, bk_we, bk_addr, bk_wdata,
    input  bk_rdata, bk_ack
  );

  modport master (
    output pmem_read, pmem_write,
    output pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp,
    input  bk_req, bk_we, bk_addr, bk_wdata,
    output bk_rdata, bk_ack
  );

endinterface

// File: rtl/pmem_line_responder.sv
// Serves 128-bit cache-line requests as 8 sequential
// 16-bit beats on a req/ack backing-memory port.
module pmem_line_responder
  import pmem_line_responder_pkg::*;
#(
  parameter int BEATS  = 8,
  parameter int WORD_W = 16,
  parameter int LINE_W = 128
) (
  input logic             clk,
  input logic             reset_n,
  pmem_line_responder_if.slave bus
);

  lc3b_pmem_state state_q, state_d;
  lc3b_beat_idx   beat_q, beat_d;
  lc3b_line_addr  line_q, line_d;
  lc3b_cache_line wdata_q, wdata_d;
  lc3b_cache_line rdata_q, rdata_d;

  logic     bk_req, bk_we, resp;
  lc3b_word bk_addr, bk_wdata;
  logic     last_beat;
  logic [6:0] slice;

  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.pmem_address[3:0];

  assign slice     = {beat_q, 4'b0000};
  assign last_beat = (beat_q == lc3b_beat_idx'(BEATS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      line_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    line_d   = line_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    bk_req   = 1'b0;
    bk_we    = 1'b0;
    bk_addr  = '0;
    bk_wdata = '0;
    resp     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // write wins if the cache ever raises both
        if (bus.pmem_write) begin
          line_d  = bus.pmem_address[15:4];
          wdata_d = bus.pmem_wdata;
          beat_d  = '0;
          state_d = WR_BEAT;
        end else if (bus.pmem_read) begin
          line_d  = bus.pmem_address[15:4];
          beat_d  = '0;
          state_d = RD_BEAT;
        end
      end
      RD_BEAT, WR_BEAT: begin
        bk_req   = 1'b1;
        bk_we    = (state_q == WR_BEAT);
        bk_addr  = beat_addr(line_q, beat_q);
        bk_wdata = wdata_q[slice +: WORD_W];
        if (bus.bk_ack) begin
          if (state_q == RD_BEAT)
            rdata_d[slice +: WORD_W] = bus.bk_rdata;
          if (last_beat)
            state_d = RESP;
          else
            beat_d = beat_q + 3'd1;
        end
      end
      RESP: begin
        resp    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.bk_req     = bk_req;
  assign bus.bk_we      = bk_we;
  assign bus.bk_addr    = bk_addr;
  assign bus.bk_wdata   = bk_wdata;
  assign bus.pmem_resp  = resp;
  assign bus.pmem_rdata = rdata_q;

endmodule

// File: doc/pmem_line_responder.md
Name: pmem_line_responder

Overview:
- Responder end of the cache's physical-memory line interface. It accepts a 128-bit cache-line read or write request on the pmem port and answers with a single-cycle pmem_resp.
- It serves each line as 8 sequential 16-bit beats on a word-wide backing-memory req/ack port.
- It sits between the L1 cache's pmem side and the word-wide main memory / SRAM controller.

Parameters:
- BEATS, 8, words per cache line (only the default is required; must equal LINE_W/WORD_W).
- WORD_W, 16, backing-memory data width.
- LINE_W, 128, cache-line width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pmem_read  in  1  line read request; held by the cache until pmem_resp.
- pmem_write  in  1  line write request; held by the cache until pmem_resp.
- pmem_address  in  16  byte address; bits [3:0] ignored (line-aligned).
- pmem_wdata  in  128  line to write; valid while pmem_write is high.
- pmem_rdata  out  128  assembled read line; valid in the pmem_resp cycle, held until the next read completes.
- pmem_resp  out  1  one-cycle completion pulse for a read or write.
- bk_req  out  1  backing-memory beat request; held until bk_ack.
- bk_we  out  1  1 = write beat, 0 = read beat; stable while bk_req is high.
- bk_addr  out  16  beat byte address {line[15:4], beat[2:0], 1'b0}.
- bk_wdata  out  16  write-beat data.
- bk_rdata  in  16  read-beat data; sampled in a cycle where bk_req and bk_ack are both high.
- bk_ack  in  1  beat complete; may be high in the first cycle of bk_req.

Behaviour:
- Reset (async, reset_n=0):
  - state IDLE; beat counter 0.
  - bk_req, bk_we, pmem_resp = 0; bk_addr, bk_wdata = 0; pmem_rdata = 0.
  - A reset mid-transaction aborts it immediately: bk_req drops asynchronously, no pmem_resp is issued, and the partial pmem_rdata is cleared.
- States: IDLE, RD_BEAT, WR_BEAT, RESP.
- IDLE:
  - pmem_write=1 → latch line address [15:4] and pmem_wdata; beat=0; go to WR_BEAT.
  - Otherwise pmem_read=1 → latch the line address; beat=0; go to RD_BEAT.
  - Both asserted → write has priority (illegal from the cache, but defined).
  - Neither asserted → stay in IDLE.
- RD_BEAT / WR_BEAT:
  - bk_req=1, bk_we=(state==WR_BEAT), bk_addr from the latched line and current beat.
  - bk_wdata = latched wdata[16*beat+15 : 16*beat].
  - On bk_ack in RD_BEAT: write bk_rdata into pmem_rdata[16*beat+15 : 16*beat].
  - On bk_ack, if beat==7 → go to RESP; else beat+1 and stay in the state. bk_req stays high across beats and bk_addr advances the next cycle.
  - bk_ack=0 → hold all outputs.
- RESP: pmem_resp=1 for exactly one cycle, then go to IDLE. The request is not re-sampled in the RESP cycle.
- Back-to-back requests: a request still asserted in the cycle after RESP is treated as a new transaction. The cache must deassert in its resp cycle, per the controller contract.
- Request drop mid-transaction: address and data are latched, so the transaction runs to completion and pmem_resp still pulses.
- pmem_address/pmem_wdata changes after acceptance are ignored.
- Latency: request seen in IDLE at cycle T → bk_req first high at T+1. With bk_ack tied high, beats complete T+1..T+8 and pmem_resp fires at T+9. Each ack stall adds one cycle.
- pmem_rdata updates only on read beats; write transactions leave it unchanged.
- Beat counter is 3 bits and never wraps outside a transaction (reset to 0 on accept).

Decomposition:
- lc3b_types:
  - Reuse lc3b_word and lc3b_cache_line.
  - Add typedef lc3b_beat_idx (logic [2:0]).
  - Add constant BEATS_PER_LINE = 8.
  - Add enum lc3b_pmem_state {IDLE, RD_BEAT, WR_BEAT, RESP}.
- Single module; no sub-module. Line assembly is an indexed part-select write into the pmem_rdata register.

Test Plan:
- Read, bk_ack=1, backing word at byte addr A = 16'h1000+2i (i=0..7) holds 16'h00i0; pmem_read at 16'h100C → bk_addr 16'h1000..16'h100E, pmem_resp at T+9, pmem_rdata = 128'h0070_0060_0050_0040_0030_0020_0010_0000.
- Write of 128'h8888_7777_6666_5555_4444_3333_2222_1111 at 16'h2000 with bk_ack low for 2 cycles on beat 3 → beats carry 16'h1111..16'h8888 at 16'h2000..16'h200E in order, beat 3 held stable for 3 cycles, pmem_resp at T+11, pmem_rdata unchanged.
- pmem_read and pmem_write both high in IDLE → write transaction (bk_we=1 on all 8 beats).
- Writeback then read with no idle gap (write to 16'h3000, read of 16'h4000 asserted the cycle after resp) → two complete transactions and two single pmem_resp pulses; the read's first bk_req is 2 cycles after the write's resp.
- reset_n low during beat 4 of a read → bk_req=0 and pmem_rdata=0 immediately, no pmem_resp; a subsequent read completes normally from beat 0.
- pmem_read dropped after acceptance and pmem_address changed to 16'hFFF0 → all beats still use the original line, and pmem_resp still pulses once.
